// File: rtl/fp_pkg.sv
// fp_pkg: shared constants and FSM state type for the single-precision divider.
//   BIAS     - IEEE-754 single exponent bias
//   EXP_W    - exponent field width
//   MAN_W    - stored mantissa (fraction) width
//   DIV_ITER - quotient bits produced by the mantissa divider
//   CNT_W    - width of the iteration counter
//   state_t  - controller states
package fp_pkg;
  localparam int BIAS     = 127;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int DIV_ITER = 25;
  localparam int CNT_W    = $clog2(DIV_ITER);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/mant_div.sv
// mant_div: restoring shift-subtract divider for two 24-bit mantissas.
// Produces one quotient bit per step, MSB first; after DIV_ITER steps the
// quotient holds floor(dividend * 2^24 / divisor).
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - capture dividend/divisor, clear quotient, preset counter
//   step       - perform one shift-subtract iteration
//   dividend   - {1, fraction} of the dividend
//   divisor    - {1, fraction} of the divisor
//   quotient   - accumulated quotient bits
//   cnt_zero   - high while the current step is the last one
module mant_div
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [MAN_W:0]   dividend,
  input  logic [MAN_W:0]   divisor,
  output logic [MAN_W+1:0] quotient,
  output logic             cnt_zero
);
  // Partial remainder stays below twice the divisor, so two guard bits suffice.
  logic [MAN_W+2:0] rem_reg;
  logic [MAN_W:0]   dsr_reg;
  logic [MAN_W+1:0] q_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic [MAN_W+2:0] dsr_ext;
  logic [MAN_W+2:0] diff;
  logic             ge;
  logic [MAN_W+2:0] rem_sel;

  always_comb begin
    dsr_ext = {2'b00, dsr_reg};
    ge      = (rem_reg >= dsr_ext);
    diff    = rem_reg - dsr_ext;
    rem_sel = ge ? diff : rem_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_reg <= '0;
      dsr_reg <= '0;
      q_reg   <= '0;
      cnt_reg <= '0;
    end else if (load) begin
      rem_reg <= {2'b00, dividend};
      dsr_reg <= divisor;
      q_reg   <= '0;
      // Preset to DIV_ITER-1 so the step that sees zero is the final one.
      cnt_reg <= CNT_W'(DIV_ITER - 1);
    end else if (step) begin
      q_reg   <= {q_reg[MAN_W:0], ge};
      rem_reg <= {rem_sel[MAN_W+1:0], 1'b0};
      if (cnt_reg != '0) cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign quotient = q_reg;
  assign cnt_zero = (cnt_reg == '0);
endmodule

// File: rtl/fp_divide.sv
// fp_divide: multi-cycle IEEE-754 single-precision divider (truncating,
// no denormals). Fixed latency: done pulses 27 cycles after the accepting edge.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - request a divide (taken only when idle and not busy)
//   FP1, FP2   - dividend, divisor
//   result     - quotient, held until the next accepted start
//   done       - one-cycle pulse when result/flags are valid
//   busy       - high from the cycle after acceptance through the done cycle
//   ovf, udf   - exponent overflow / underflow
//   div0       - divisor was zero
module fp_divide
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] FP1,
  input  logic [31:0] FP2,
  output logic [31:0] result,
  output logic        done,
  output logic        busy,
  output logic        ovf,
  output logic        udf,
  output logic        div0
);
  state_t state_reg, state_next;

  logic                sign_reg;
  logic                a_zero_reg;
  logic                b_zero_reg;
  logic signed [9:0]   exp_reg;
  logic [MAN_W-1:0]    man_reg;

  logic                accept;
  logic                load;
  logic                step;
  logic [MAN_W+1:0]    quotient;
  logic                cnt_zero;
  logic signed [9:0]   exp_init;

  logic [31:0]         res_pack;
  logic                ovf_pack, udf_pack, div0_pack;

  assign accept   = (state_reg == IDLE) && start && !busy;
  assign exp_init = $signed({2'b00, FP1[30:23]}) - $signed({2'b00, FP2[30:23]})
                  + 10'(BIAS);

  mant_div u_mant_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .step     (step),
    .dividend ({1'b1, FP1[MAN_W-1:0]}),
    .divisor  ({1'b1, FP2[MAN_W-1:0]}),
    .quotient (quotient),
    .cnt_zero (cnt_zero)
  );

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          load       = 1'b1;
          state_next = DIVIDE;
        end
      end
      DIVIDE: begin
        step = 1'b1;
        if (cnt_zero) state_next = NORM;
      end
      NORM:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Special operands override the arithmetic path, which keeps the flags
  // mutually exclusive.
  always_comb begin
    res_pack  = {sign_reg, exp_reg[EXP_W-1:0], man_reg};
    ovf_pack  = 1'b0;
    udf_pack  = 1'b0;
    div0_pack = 1'b0;
    if (b_zero_reg && a_zero_reg) begin
      res_pack  = 32'h7FC0_0000;
      div0_pack = 1'b1;
    end else if (b_zero_reg) begin
      res_pack  = {sign_reg, 8'hFF, 23'h0};
      div0_pack = 1'b1;
    end else if (a_zero_reg) begin
      res_pack  = {sign_reg, 31'h0};
    end else if (exp_reg >= 10'sd255) begin
      res_pack  = {sign_reg, 8'hFF, 23'h0};
      ovf_pack  = 1'b1;
    end else if (exp_reg <= 10'sd0) begin
      res_pack  = {sign_reg, 31'h0};
      udf_pack  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      sign_reg   <= 1'b0;
      a_zero_reg <= 1'b0;
      b_zero_reg <= 1'b0;
      exp_reg    <= '0;
      man_reg    <= '0;
      result     <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
      div0       <= 1'b0;
    end else begin
      state_reg <= state_next;
      done      <= 1'b0;

      if (accept) begin
        busy       <= 1'b1;
        result     <= '0;
        ovf        <= 1'b0;
        udf        <= 1'b0;
        div0       <= 1'b0;
        sign_reg   <= FP1[31] ^ FP2[31];
        a_zero_reg <= (FP1[30:23] == '0);
        b_zero_reg <= (FP2[30:23] == '0);
        exp_reg    <= exp_init;
      end else if (done) begin
        busy <= 1'b0;
      end

      // Quotient in [0.5, 2): a clear integer bit means one extra shift.
      if (state_reg == NORM) begin
        if (quotient[MAN_W+1]) begin
          man_reg <= quotient[MAN_W:1];
        end else begin
          man_reg <= quotient[MAN_W-1:0];
          exp_reg <= exp_reg - 10'sd1;
        end
      end

      if (state_reg == DONE) begin
        result <= res_pack;
        ovf    <= ovf_pack;
        udf    <= udf_pack;
        div0   <= div0_pack;
        done   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fp_divide.sv
// tb_fp_divide: self-checking bench for fp_divide. Expected results are
// queued when a divide is issued and compared when done pulses.
module tb_fp_divide;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] FP1 = '0;
  logic [31:0] FP2 = '0;
  logic [31:0] result;
  logic        done, busy, ovf, udf, div0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        ovf;
    logic        udf;
    logic        div0;
  } exp_t;

  exp_t sb_q[$];

  fp_divide dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .FP1    (FP1),
    .FP2    (FP2),
    .result (result),
    .done   (done),
    .busy   (busy),
    .ovf    (ovf),
    .udf    (udf),
    .div0   (div0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic o, input logic u, input logic z);
    exp_t e;
    e.res = r; e.ovf = o; e.udf = u; e.div0 = z;
    return e;
  endfunction

  // Reference: integer long division of the mantissas, truncated.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    logic [48:0] num;
    logic [48:0] q;
    int          e;
    logic        s;
    logic [22:0] m;
    s = a[31] ^ b[31];
    if (b[30:23] == 0 && a[30:23] == 0) return mk(32'h7FC00000, 0, 0, 1);
    if (b[30:23] == 0) return mk({s, 8'hFF, 23'h0}, 0, 0, 1);
    if (a[30:23] == 0) return mk({s, 31'h0}, 0, 0, 0);
    num = {1'b1, a[22:0]};
    num = num << 24;
    q = num / {25'h0, 1'b1, b[22:0]};
    e = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q[24]) m = q[23:1];
    else begin
      m = q[22:0];
      e = e - 1;
    end
    if (e >= 255) return mk({s, 8'hFF, 23'h0}, 1, 0, 0);
    if (e <= 0) return mk({s, 31'h0}, 0, 1, 0);
    return mk({s, e[7:0], m}, 0, 0, 0);
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input exp_t e, output int acc);
    @(negedge clk);
    FP1 = a; FP2 = b; start = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    acc = cyc;
    start = 1'b0;
    // Operands must already be captured; scramble them.
    FP1 = $urandom; FP2 = $urandom;
    @(negedge clk);
    check("busy_after_accept", {31'h0, busy}, 32'h1);
  endtask

  task automatic wait_done(input string tag, input int acc);
    int   n = 0;
    exp_t e;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      check({tag, "_timeout"}, 32'h0, 32'h1);
      void'(sb_q.pop_front());
    end else begin
      e = sb_q.pop_front();
      $display("txn %s: result=%h ovf=%0d udf=%0d div0=%0d latency=%0d",
               tag, result, ovf, udf, div0, cyc - acc);
      check({tag, "_result"}, result, e.res);
      check({tag, "_flags"}, {29'h0, ovf, udf, div0}, {29'h0, e.ovf, e.udf, e.div0});
      check({tag, "_latency"}, 32'(cyc - acc), 32'd27);
      check({tag, "_busy_in_done"}, {31'h0, busy}, 32'h1);
      @(negedge clk);
      check({tag, "_done_pulse"}, {30'h0, done, busy}, 32'h0);
      check({tag, "_held"}, result, e.res);
    end
  endtask

  initial begin
    int          acc;
    int          dcount;
    logic [31:0] ra, rb;

    // Reset state
    #3;
    check("reset_outs", {result[31:0]}, 32'h0);
    check("reset_flags", {27'h0, done, busy, ovf, udf, div0}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    issue(32'h40C00000, 32'h40000000, mk(32'h40400000, 0, 0, 0), acc);
    wait_done("6.0/2.0", acc);
    issue(32'h3F800000, 32'h40400000, mk(32'h3EAAAAAA, 0, 0, 0), acc);
    wait_done("1.0/3.0", acc);
    issue(32'hC0F00000, 32'h40200000, mk(32'hC0400000, 0, 0, 0), acc);
    wait_done("-7.5/2.5", acc);
    issue(32'h3F800000, 32'h00000000, mk(32'h7F800000, 0, 0, 1), acc);
    wait_done("1/0", acc);
    issue(32'h00000000, 32'h00000000, mk(32'h7FC00000, 0, 0, 1), acc);
    wait_done("0/0", acc);
    issue(32'h80000000, 32'h3F800000, mk(32'h80000000, 0, 0, 0), acc);
    wait_done("-0/1", acc);
    issue(32'h7F000000, 32'h00800000, mk(32'h7F800000, 1, 0, 0), acc);
    wait_done("ovf", acc);
    issue(32'h00800000, 32'h7F000000, mk(32'h00000000, 0, 1, 0), acc);
    wait_done("udf", acc);
    issue(32'h7F800000, 32'h3F800000, mk(32'h7F800000, 1, 0, 0), acc);
    wait_done("exp255", acc);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      issue(ra, rb, model(ra, rb), acc);
      wait_done($sformatf("rand%0d", i), acc);
    end

    // Reset in the middle of a divide: no done, everything cleared.
    @(negedge clk);
    FP1 = 32'h40C00000; FP2 = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outs", result, 32'h0);
    check("abort_flags", {27'h0, done, busy, ovf, udf, div0}, 32'h0);
    dcount = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("abort_no_done", 32'(dcount), 32'h0);
    $display("txn abort: dones_after_reset=%0d", dcount);

    // Second start while busy must be ignored.
    issue(32'h40C00000, 32'h40000000, mk(32'h40400000, 0, 0, 0), acc);
    repeat (4) @(negedge clk);
    FP1 = 32'h3F800000; FP2 = 32'h40400000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore_start", acc);
    dcount = 0;
    repeat (35) begin
      @(negedge clk);
      if (done) dcount++;
    end
    check("single_done", 32'(dcount), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
